mul_div_sequencer: RTL and testbench
====================================

MUL_DIV_SEQUENCER -- requirements
Module: mul_div_sequencer

Interface
REQ-001 The block SHALL take one parameter: XLEN, default 32, operand and result width.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 Port clk: input, 1 bit, rising-edge clock.
REQ-004 Port rst_n: input, 1 bit, asynchronous active-low reset.
REQ-005 Port start: input, 1 bit, M-extension op valid in EX; held high by the pipeline until result_valid.
REQ-006 Port func3: input, 3 bits, RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 Port opa: input, XLEN bits, rs1 value.
REQ-008 Port opb: input, XLEN bits, rs2 value.
REQ-009 Port flush: input, 1 bit, kill the in-flight operation.
REQ-010 Port stall: output, 1 bit, freezes the pipeline front end.
REQ-011 Port result_valid: output, 1 bit, registered one-cycle result strobe.
REQ-012 Port result: output, XLEN bits, registered result, valid when result_valid is high.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, CALC, DONE.
REQ-014 In IDLE with start=1 and flush=0, the block SHALL latch func3, opa and opb.
- It SHALL convert signed operands to magnitudes: rs1 for MULH, MULHSU, DIV and REM; rs2 for MULH, DIV and REM.
- It SHALL load the bit counter with XLEN.
REQ-015 A special case (divide op with opb=0, or DIV/REM with opa=0x80000000 and opb=0xFFFFFFFF) SHALL go IDLE->DONE in one cycle, bypassing CALC.
REQ-016 All other accepted ops SHALL go IDLE->CALC.
- CALC SHALL process one bit per cycle: shift-add for multiply, restoring shift-subtract for divide.
- The counter SHALL decrement each cycle.
- CALC->DONE SHALL occur on the cycle the counter reaches 1.
REQ-017 Latency SHALL be: start sampled at edge T gives result_valid high during cycle T+XLEN+1 for normal ops and T+1 for special cases.
REQ-018 In DONE, result_valid SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE unconditionally; start is ignored in DONE.
REQ-019 stall SHALL equal (state==IDLE && start && !flush) || state==CALC; stall SHALL be 0 in DONE.
REQ-020 start and operand changes in CALC SHALL be ignored.
REQ-021 The multiply result SHALL be computed as follows.
- The full product SHALL be 2*XLEN bits.
- MUL SHALL return the low half.
- MULH, MULHSU and MULHU SHALL return the high half.
- The product SHALL be negated (two's complement, 2*XLEN bits) when the operand signs per REQ-014 differ.
REQ-022 The divide result sign SHALL be as follows: quotient negated when the signs differ; remainder takes the sign of opa.
REQ-023 Divide-by-zero SHALL return as follows: DIV and DIVU return all ones; REM and REMU return opa unchanged.
REQ-024 Overflow (DIV of 0x80000000 by -1) SHALL return quotient 0x80000000 and remainder 0.
REQ-025 Flush in CALC or DONE SHALL force IDLE on the next edge with result_valid=0.
- The partial result SHALL be discarded.
- result SHALL hold its previous value.
REQ-026 Flush in IDLE SHALL take priority over start; no operation is accepted.
REQ-027 A start in the first IDLE cycle after DONE SHALL be accepted as a new operation, allowing back-to-back ops.

Reset
REQ-028 While rst_n=0, the block SHALL hold:
- state IDLE and counter 0;
- result_valid 0 and result 0;
- stall 0, regardless of start;
- all internal operand and accumulator registers cleared.
REQ-029 Reset SHALL take effect immediately (asynchronously), including mid-CALC, and operation SHALL resume on the first rising edge after rst_n rises.

Verification
REQ-030 MUL opa=7, opb=0xFFFFFFFD -> result 0xFFFFFFEB; stall high for 33 cycles; result_valid at T+33.
REQ-031 MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
REQ-032 DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM 0xFFFFFFF9/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-033 Special cases: DIVU 5/0 -> 0xFFFFFFFF at T+1; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
REQ-034 Flush at T+10 of a DIV -> IDLE at T+11; no result_valid; stall 0; the next start is accepted and returns the correct result.
REQ-035 rst_n low at T+5 of a MUL -> result_valid=0, result=0 and stall=0 immediately; a fresh MUL after release returns the correct value.

Source files
------------

// File: rtl/mul_div_sequencer_if.sv
// Handshake/operand bundle between the EX stage and the iterative RV32M unit.
interface mul_div_sequencer_if #(parameter int XLEN = 32);
  logic            start;
  logic [2:0]      func3;
  logic [XLEN-1:0] opa;
  logic [XLEN-1:0] opb;
  logic            flush;
  logic            stall;
  logic            result_valid;
  logic [XLEN-1:0] result;

  modport master (output start, func3, opa, opb, flush,
                  input  stall, result_valid, result);
  modport slave  (input  start, func3, opa, opb, flush,
                  output stall, result_valid, result);
endinterface

// File: rtl/mul_div_sequencer.sv
// Iterative RV32M unit: one bit per cycle shift-add multiply / restoring divide,
// with single-cycle handling of divide-by-zero and signed overflow.
module mul_div_sequencer #(
  parameter int XLEN = 32
) (
  input logic                clk,
  input logic                rst_n,
  mul_div_sequencer_if.slave bus
);
  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nxt;

  logic [2:0]        op;
  logic [XLEN-1:0]   mcand;     // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] acc;       // {hi, lo}: product / {remainder, quotient}
  logic              neg_res, neg_rem;
  logic [CW-1:0]     cnt;
  logic              vld_q;
  logic [XLEN-1:0]   res_q;

  logic              sgn_a, sgn_b, is_div, div_zero, div_ovf, special, accept;
  logic [XLEN-1:0]   mag_a, mag_b, special_res;

  // Operand decode, only meaningful while IDLE
  always_comb begin
    sgn_a = 1'b0;
    sgn_b = 1'b0;
    case (bus.func3)
      3'b001, 3'b100, 3'b110: begin
        sgn_a = bus.opa[XLEN-1];
        sgn_b = bus.opb[XLEN-1];
      end
      3'b010:  sgn_a = bus.opa[XLEN-1];
      default: ;
    endcase
    mag_a    = sgn_a ? -bus.opa : bus.opa;
    mag_b    = sgn_b ? -bus.opb : bus.opb;
    is_div   = bus.func3[2];
    div_zero = is_div && (bus.opb == '0);
    div_ovf  = is_div && !bus.func3[0] && (bus.opb == '1) &&
               (bus.opa == {1'b1, {(XLEN-1){1'b0}}});
    special  = div_zero || div_ovf;
    if (div_zero) special_res = bus.func3[1] ? bus.opa : '1;
    else          special_res = bus.func3[1] ? '0 : bus.opa;
    accept   = bus.start && !bus.flush;
  end

  logic [XLEN:0]     add_sum, rem_sh, sub_diff;
  logic [2*XLEN-1:0] acc_step, prod_s;
  logic [XLEN-1:0]   q_s, r_s, res_fin;

  // One iteration step plus sign fix-up of the value it produces
  always_comb begin
    add_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, mcand};
    rem_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    sub_diff = rem_sh - {1'b0, mcand};
    if (!op[2])
      acc_step = acc[0] ? {add_sum, acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]};
    else if (!sub_diff[XLEN])
      acc_step = {sub_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    else
      acc_step = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    prod_s = neg_res ? -acc_step : acc_step;
    q_s    = neg_res ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
    r_s    = neg_rem ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
    case (op)
      3'b000:                 res_fin = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: res_fin = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         res_fin = q_s;
      default:                res_fin = r_s;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = special ? DONE : CALC;
      CALC: begin
        if (bus.flush)              state_nxt = IDLE;
        else if (cnt == CW'(1))     state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op      <= '0;
      mcand   <= '0;
      acc     <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      cnt     <= '0;
      vld_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      vld_q <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          op      <= bus.func3;
          neg_res <= sgn_a ^ sgn_b;
          neg_rem <= sgn_a;
          cnt     <= CW'(XLEN);
          if (is_div) begin
            mcand <= mag_b;
            acc   <= {{XLEN{1'b0}}, mag_a};
          end else begin
            mcand <= mag_a;
            acc   <= {{XLEN{1'b0}}, mag_b};
          end
          if (special) begin
            res_q <= special_res;
            vld_q <= 1'b1;
          end
        end
        CALC: if (!bus.flush) begin
          acc <= acc_step;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            res_q <= res_fin;
            vld_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.stall        = rst_n && ((state == IDLE && accept) || state == CALC);
  assign bus.result_valid = vld_q;
  assign bus.result       = res_q;
endmodule

// File: tb/tb_mul_div_sequencer.sv
// Directed vector table plus hand sequences for flush, reset and back-to-back ops.
module tb_mul_div_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nchecks = 0;
  int   nerr = 0;

  mul_div_sequencer_if #(.XLEN(32)) bus();
  mul_div_sequencer #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Presents an op and waits for result_valid; operands are scrambled mid-CALC.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input bit keep, output int lat, output logic [31:0] r,
                        output int stalls);
    @(negedge clk);
    bus.start = 1'b1; bus.func3 = f; bus.opa = a; bus.opb = b;
    #1;
    lat = -1; stalls = 0; r = '0;
    for (int k = 0; k < 60; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 5) begin
        bus.opa = $urandom; bus.opb = $urandom; bus.func3 = 3'($urandom_range(0, 7));
      end
      if (bus.stall) stalls++;
      if (bus.result_valid) begin
        lat = k; r = bus.result; break;
      end
    end
    if (!keep) begin
      bus.start = 1'b0;
      @(negedge clk);
      chk("valid_one_cycle", 32'(bus.result_valid), 32'd0);
      chk("stall_after_done", 32'(bus.stall), 32'd0);
    end
  endtask

  initial begin
    int lat, stalls;
    logic [31:0] r, held;
    bit seen;

    vecs.push_back('{3'b000, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFEB, 33});
    vecs.push_back('{3'b001, 32'h80000000,  32'h80000000, 32'h40000000, 33});
    vecs.push_back('{3'b011, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFE, 33});
    vecs.push_back('{3'b010, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFF, 33});
    vecs.push_back('{3'b100, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD, 33});
    vecs.push_back('{3'b110, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF, 33});
    vecs.push_back('{3'b101, 32'd100,       32'd7,        32'd14,       33});
    vecs.push_back('{3'b111, 32'd100,       32'd7,        32'd2,        33});
    vecs.push_back('{3'b101, 32'd5,         32'd0,        32'hFFFFFFFF, 1});
    vecs.push_back('{3'b110, 32'd5,         32'd0,        32'd5,        1});
    vecs.push_back('{3'b100, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, 1});
    vecs.push_back('{3'b110, 32'h80000000,  32'hFFFFFFFF, 32'd0,        1});
    vecs.push_back('{3'b100, 32'd5,         32'd0,        32'hFFFFFFFF, 1});
    vecs.push_back('{3'b111, 32'd5,         32'd0,        32'd5,        1});
    vecs.push_back('{3'b001, 32'hFFFFFFFF,  32'd5,        32'hFFFFFFFF, 33});
    vecs.push_back('{3'b011, 32'h80000000,  32'd2,        32'd1,        33});
    vecs.push_back('{3'b000, 32'h0000FFFF,  32'h0000FFFF, 32'hFFFE0001, 33});
    vecs.push_back('{3'b100, 32'd7,         32'hFFFFFFFE, 32'hFFFFFFFD, 33});
    vecs.push_back('{3'b110, 32'd7,         32'hFFFFFFFE, 32'd1,        33});
    vecs.push_back('{3'b100, 32'hFFFFFFF9,  32'hFFFFFFFE, 32'd3,        33});
    vecs.push_back('{3'b100, 32'h80000000,  32'd2,        32'hC0000000, 33});
    vecs.push_back('{3'b101, 32'h80000000,  32'd2,        32'h40000000, 33});

    bus.start = 1'b1; bus.func3 = 3'b000; bus.opa = 32'd3; bus.opb = 32'd4; bus.flush = 1'b0;
    #12;
    chk("reset_stall", 32'(bus.stall), 32'd0);
    chk("reset_valid", 32'(bus.result_valid), 32'd0);
    chk("reset_result", bus.result, 32'd0);
    bus.start = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, 1'b0, lat, r, stalls);
      chk($sformatf("vec%0d_result", i), r, vecs[i].exp);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("vec%0d_stall_cycles", i), 32'(stalls), 32'(vecs[i].lat));
    end

    // Back-to-back: start held through DONE, new op accepted in the next IDLE cycle
    run_op(3'b101, 32'd100, 32'd7, 1'b1, lat, r, stalls);
    chk("b2b_first", r, 32'd14);
    run_op(3'b000, 32'd6, 32'd9, 1'b0, lat, r, stalls);
    chk("b2b_second", r, 32'd54);
    chk("b2b_latency", 32'(lat), 32'd33);

    // Flush mid-divide
    held = bus.result;
    @(negedge clk);
    bus.start = 1'b1; bus.func3 = 3'b100; bus.opa = 32'd1000; bus.opb = 32'd3;
    for (int k = 0; k < 10; k++) @(negedge clk);
    chk("flush_pre_stall", 32'(bus.stall), 32'd1);
    bus.flush = 1'b1; bus.start = 1'b0;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_stall", 32'(bus.stall), 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.result_valid) seen = 1'b1;
    end
    chk("flush_no_valid", 32'(seen), 32'd0);
    chk("flush_result_held", bus.result, held);
    run_op(3'b100, 32'hFFFFFFF9, 32'd2, 1'b0, lat, r, stalls);
    chk("post_flush_result", r, 32'hFFFFFFFD);

    // Flush in IDLE beats start
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1; bus.func3 = 3'b000; bus.opa = 32'd2; bus.opb = 32'd2;
    #1;
    chk("idle_flush_stall", 32'(bus.stall), 32'd0);
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    #1;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (bus.result_valid || bus.stall) seen = 1'b1;
      @(negedge clk);
    end
    chk("idle_flush_no_op", 32'(seen), 32'd0);

    // Asynchronous reset mid-multiply
    @(negedge clk);
    bus.start = 1'b1; bus.func3 = 3'b000; bus.opa = 32'd5; bus.opb = 32'd5;
    for (int k = 0; k < 5; k++) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(bus.result_valid), 32'd0);
    chk("rst_mid_result", bus.result, 32'd0);
    chk("rst_mid_stall", 32'(bus.stall), 32'd0);
    bus.start = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    run_op(3'b000, 32'd7, 32'hFFFFFFFD, 1'b0, lat, r, stalls);
    chk("post_rst_result", r, 32'hFFFFFFEB);
    chk("post_rst_latency", 32'(lat), 32'd33);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end
endmodule
